// File: rtl/servo_ramp.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// servo_ramp
//
// Command stage in front of the servo pulse generator. It latches requested
// pulse widths (in microseconds) and clamps them to [MIN_US, MAX_US]. It then
// moves pulse_len toward that target by at most STEP_US once per servo frame,
// so the output never jumps.
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   target_us     in   requested pulse width, us (16-bit unsigned)
//   target_valid  in   one-cycle strobe; target_us is sampled while high
//   sweep         in   (only with SERVO_RAMP_SWEEP_EN) ping-pong between limits
//   pulse_len     out  current commanded pulse width, us
//   frame_tick    out  one-cycle pulse at every frame boundary
//   busy          out  high while pulse_len is still moving toward the target
//   clamped       out  one-cycle pulse when an accepted target was out of range
//
// Optional feature macro: SERVO_RAMP_SWEEP_EN
//   When defined, the block has a sweep input. While sweep is high,
//   target_valid is ignored and the target alternates between MAX_US and
//   MIN_US. Each new limit is loaded when sweep is first raised, and again
//   every time the ramp to the previous limit completes.
// -----------------------------------------------------------------------------
module servo_ramp #(
  parameter int CLK_F     = 25,
  parameter int FRAME_US  = 20000,
  parameter int MIN_US    = 1000,
  parameter int MAX_US    = 2000,
  parameter int CENTRE_US = 1500,
  parameter int STEP_US   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] target_us,
  input  logic        target_valid,
`ifdef SERVO_RAMP_SWEEP_EN
  input  logic        sweep,
`endif
  output logic [15:0] pulse_len,
  output logic        frame_tick,
  output logic        busy,
  output logic        clamped
);

  localparam int PW = (CLK_F > 1) ? $clog2(CLK_F) : 1;
  localparam int UW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_F - 1);
  localparam logic [UW-1:0] US_LAST  = UW'(FRAME_US - 1);

  localparam logic [15:0] MIN_V    = 16'(MIN_US);
  localparam logic [15:0] MAX_V    = 16'(MAX_US);
  localparam logic [15:0] CENTRE_V = 16'(CENTRE_US);
  localparam logic [15:0] STEP_V   = 16'(STEP_US);

  localparam logic signed [16:0] STEP_POS = 17'(STEP_US);
  localparam logic signed [16:0] STEP_NEG = -STEP_POS;

  typedef enum logic {IDLE, RAMP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [UW-1:0] us_q, us_d;
  logic [15:0]   pulse_q, pulse_d;
  logic [15:0]   target_q, target_d;
  logic          frame_tick_q, frame_tick_d;
  logic          busy_q, busy_d;
  logic          clamped_q, clamped_d;

  logic          presc_wrap;
  logic          frame_wrap;
  logic          below_min;
  logic          above_max;
  logic [15:0]   target_clamped;
  logic signed [16:0] diff;
  logic          near;

`ifdef SERVO_RAMP_SWEEP_EN
  logic sweep_q, sweep_d;
  logic last_max_q, last_max_d;   // last limit loaded by the sweep was MAX_US
  logic sweep_load;
`endif

  // ---------------------------------------------------------------------------
  // Timebase: clk -> 1 us ticks -> frame counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    presc_wrap   = (presc_q == PRE_LAST);
    frame_wrap   = presc_wrap && (us_q == US_LAST);
    presc_d      = presc_wrap ? '0 : presc_q + 1'b1;
    us_d         = us_q;
    if (presc_wrap) begin
      us_d = (us_q == US_LAST) ? '0 : us_q + 1'b1;
    end
    frame_tick_d = frame_wrap;
  end

  // ---------------------------------------------------------------------------
  // Target acceptance. The latest strobe always wins. Clamping happens here,
  // so the ramp logic only ever sees in-range targets.
  // ---------------------------------------------------------------------------
  always_comb begin
    below_min      = (target_us < MIN_V);
    above_max      = (target_us > MAX_V);
    target_clamped = below_min ? MIN_V : (above_max ? MAX_V : target_us);
    target_d       = target_q;
    clamped_d      = 1'b0;
`ifdef SERVO_RAMP_SWEEP_EN
    sweep_d    = sweep;
    last_max_d = last_max_q;
    // Load the next limit when sweep rises, or once the previous limit has
    // been reached (IDLE with the target already equal to pulse_len).
    sweep_load = sweep && (!sweep_q || ((state_q == IDLE) && (target_q == pulse_q)));
    if (sweep_load) begin
      target_d   = last_max_q ? MIN_V : MAX_V;
      last_max_d = !last_max_q;
    end else if (!sweep && target_valid) begin
      target_d  = target_clamped;
      clamped_d = below_min || above_max;
    end
`else
    if (target_valid) begin
      target_d  = target_clamped;
      clamped_d = below_min || above_max;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Ramp FSM. pulse_len only moves on the frame wrap edge. Because the step
  // uses target_q, a strobe in the same cycle takes effect one frame later.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pulse_d = pulse_q;
    diff    = $signed({1'b0, target_q}) - $signed({1'b0, pulse_q});
    near    = (diff <= STEP_POS) && (diff >= STEP_NEG);
    case (state_q)
      IDLE: begin
        if (target_q != pulse_q) begin
          state_d = RAMP;
        end
      end
      RAMP: begin
        if (frame_wrap) begin
          if (near) begin
            // Final partial step lands exactly on the target: no overshoot.
            pulse_d = target_q;
            state_d = IDLE;
          end else if (diff[16]) begin
            pulse_d = pulse_q - STEP_V;
          end else begin
            pulse_d = pulse_q + STEP_V;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RAMP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      us_q         <= '0;
      pulse_q      <= CENTRE_V;
      target_q     <= CENTRE_V;
      frame_tick_q <= 1'b0;
      busy_q       <= 1'b0;
      clamped_q    <= 1'b0;
`ifdef SERVO_RAMP_SWEEP_EN
      sweep_q      <= 1'b0;
      last_max_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      us_q         <= us_d;
      pulse_q      <= pulse_d;
      target_q     <= target_d;
      frame_tick_q <= frame_tick_d;
      busy_q       <= busy_d;
      clamped_q    <= clamped_d;
`ifdef SERVO_RAMP_SWEEP_EN
      sweep_q      <= sweep_d;
      last_max_q   <= last_max_d;
`endif
    end
  end

  assign pulse_len  = pulse_q;
  assign frame_tick = frame_tick_q;
  assign busy       = busy_q;
  assign clamped    = clamped_q;

endmodule

// File: tb/tb_servo_ramp.sv
`timescale 1ns/1ps
// Testbench for servo_ramp (CLK_F=1, FRAME_US=100). A frame-level reference
// model predicts pulse_len/busy at every frame boundary and queues the
// prediction. A monitor pops and compares whenever the DUT raises frame_tick.
module tb_servo_ramp;

  localparam int CLK_F     = 1;
  localparam int FRAME_US  = 100;
  localparam int MIN_US    = 1000;
  localparam int MAX_US    = 2000;
  localparam int CENTRE_US = 1500;
  localparam int STEP_US   = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] target_us = 16'd0;
  logic        target_valid = 1'b0;
`ifdef SERVO_RAMP_SWEEP_EN
  logic        sweep = 1'b0;
`endif
  logic [15:0] pulse_len;
  logic        frame_tick;
  logic        busy;
  logic        clamped;

  always #5 clk = ~clk;

  servo_ramp #(
    .CLK_F(CLK_F), .FRAME_US(FRAME_US), .MIN_US(MIN_US), .MAX_US(MAX_US),
    .CENTRE_US(CENTRE_US), .STEP_US(STEP_US)
  ) dut (
    .clk(clk),
    .reset(reset),
    .target_us(target_us),
    .target_valid(target_valid),
`ifdef SERVO_RAMP_SWEEP_EN
    .sweep(sweep),
`endif
    .pulse_len(pulse_len),
    .frame_tick(frame_tick),
    .busy(busy),
    .clamped(clamped)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; int pulse; bit busy; } exp_t;
  exp_t exp_q[$];

  // Reference model state: cycle count since reset release, target, output.
  int n = 0;
  int m_target = CENTRE_US;
  int m_pulse  = CENTRE_US;
  bit m_active = 1'b0;
  int m_d;
`ifdef SERVO_RAMP_SWEEP_EN
  bit m_sweep_prev = 1'b0;
  bit m_last_max   = 1'b0;
`endif

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, n);
    end
  endtask

  function automatic int clamp_us(input int v);
    if (v < MIN_US) return MIN_US;
    if (v > MAX_US) return MAX_US;
    return v;
  endfunction

  // Reference model: at each frame boundary, move by at most STEP_US toward the
  // target. Then apply any strobe; the new target counts from the next frame.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        n        = 0;
        m_target = CENTRE_US;
        m_pulse  = CENTRE_US;
        m_active = 1'b0;
`ifdef SERVO_RAMP_SWEEP_EN
        m_sweep_prev = 1'b0;
        m_last_max   = 1'b0;
`endif
        exp_q.delete();
      end else begin
        n++;
        if (n % FRAME_US == 0) begin
          if (m_active) begin
            m_d = m_target - m_pulse;
            if (m_d <= STEP_US && m_d >= -STEP_US) begin
              m_pulse  = m_target;
              m_active = 1'b0;
            end else begin
              m_pulse = m_pulse + ((m_d > 0) ? STEP_US : -STEP_US);
            end
          end
          exp_q.push_back('{n, m_pulse, m_active});
        end
`ifdef SERVO_RAMP_SWEEP_EN
        if (sweep) begin
          if (!m_sweep_prev || !m_active) begin
            m_target   = m_last_max ? MIN_US : MAX_US;
            m_last_max = !m_last_max;
            m_active   = (m_target != m_pulse);
          end
        end else
`endif
        if (target_valid) begin
          m_target = clamp_us(int'(target_us));
          m_active = (m_target != m_pulse);
        end
`ifdef SERVO_RAMP_SWEEP_EN
        m_sweep_prev = sweep;
`endif
      end
    end
  end

  // Monitor: pops a prediction each time the DUT presents frame_tick.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("pulse_hold", int'(pulse_len), m_pulse);
        while (exp_q.size() > 0 && exp_q[0].cyc < n) begin
          e = exp_q.pop_front();
          check("missed_tick", n, e.cyc);
        end
        if (frame_tick) begin
          if (exp_q.size() == 0) begin
            check("unexpected_tick", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("tick_cycle", n, e.cyc);
            check("tick_pulse", int'(pulse_len), e.pulse);
            check("tick_busy", int'(busy), int'(e.busy));
          end
        end
      end
    end
  end

  task automatic wait_pos(input int p);
    do @(negedge clk); while (n % FRAME_US != p);
  endtask

  task automatic frames(input int k);
    repeat (k) wait_pos(10);
  endtask

  // Issue one strobe (call right after a negedge), then check clamped and busy.
  task automatic strobe(input int v);
    bit was_active;
    int exp_cl;
    was_active   = m_active;
    exp_cl       = (v < MIN_US || v > MAX_US) ? 1 : 0;
    target_us    = 16'(v);
    target_valid = 1'b1;
    @(posedge clk); #1;
    check("clamped_pulse", int'(clamped), exp_cl);
    target_valid = 1'b0;
    @(posedge clk); #1;
    check("clamped_clear", int'(clamped), 0);
    if (m_target != m_pulse) check("busy_after_strobe", int'(busy), 1);
    else if (!was_active) check("busy_after_strobe", int'(busy), 0);
    $display("strobe target_us=%0d -> model target %0d, pulse %0d", v, m_target, m_pulse);
    @(negedge clk);
  endtask

  initial begin
    int p;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pulse", int'(pulse_len), CENTRE_US);
    check("rst_busy", int'(busy), 0);
    check("rst_tick", int'(frame_tick), 0);
    check("rst_clamped", int'(clamped), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rel_pulse", int'(pulse_len), CENTRE_US);
    check("rel_tick", int'(frame_tick), 0);
    @(negedge clk);

    // Small ramp up: 1510, 1520, 1530, 1540
    wait_pos(10);
    strobe(1540);
    frames(5);
    check("ramp1540_final", int'(pulse_len), 1540);
    check("ramp1540_busy", int'(busy), 0);

    // Over-range request clamps to MAX_US
    strobe(2500);
    frames(55);
    check("clamp_final", int'(pulse_len), MAX_US);
    strobe(1500);
    frames(52);

    // Retarget mid-ramp with direction reversal
    strobe(1540);
    frames(2);
    check("retarget_mid", int'(pulse_len), 1520);
    strobe(1495);
    frames(4);
    check("retarget_final", int'(pulse_len), 1495);
    check("retarget_busy", int'(busy), 0);

    // Strobe coincident with a frame tick: the step still uses the old target
    strobe(1540);
    frames(1);
    wait_pos(FRAME_US - 1);
    strobe(1400);
    check("simul_old_target", int'(pulse_len), 1515);
    frames(14);
    check("simul_final", int'(pulse_len), 1400);

    // Reset mid-ramp
    strobe(1600);
    frames(13);
    check("pre_reset_pulse", int'(pulse_len), 1530);
    #2 reset = 1'b1;
    #1;
    check("async_rst_pulse", int'(pulse_len), CENTRE_US);
    check("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    frames(3);
    check("post_rst_pulse", int'(pulse_len), CENTRE_US);
    check("post_rst_busy", int'(busy), 0);

    // Randomized strobes at random frame positions
    for (int i = 0; i < 30; i++) begin
      frames(int'($urandom_range(0, 3)));
      p = ($urandom_range(0, 4) == 0) ? FRAME_US - 1 : int'($urandom_range(5, 90));
      wait_pos(p);
      strobe(int'($urandom_range(800, 2300)));
    end
    frames(2);

`ifdef SERVO_RAMP_SWEEP_EN
    // Sweep: up to MAX_US, then down to MIN_US; strobes ignored
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_pos(10);
    sweep = 1'b1;
    @(negedge clk);
    target_us    = 16'd500;
    target_valid = 1'b1;
    @(posedge clk); #1;
    check("sweep_ignore_clamped", int'(clamped), 0);
    target_valid = 1'b0;
    @(negedge clk);
    frames(50);
    check("sweep_top", int'(pulse_len), MAX_US);
    frames(100);
    check("sweep_bottom", int'(pulse_len), MIN_US);
    sweep = 1'b0;
    frames(3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
